// File: rtl/alu_ex_stage_pkg.sv
// Shared types for the EX/MEM stage: ALU op codes, the captured payload and
// the skid-buffer occupancy states.
package alu_ex_stage_pkg;

    localparam int P_WIDTH = 32;
    localparam int P_RD_W  = 5;

    localparam logic [1:0] ALU_AND = 2'd0;
    localparam logic [1:0] ALU_OR  = 2'd1;
    localparam logic [1:0] ALU_ADD = 2'd2;
    localparam logic [1:0] ALU_CMP = 2'd3;

    typedef struct packed {
        logic [P_WIDTH-1:0] result;
        logic               zero;
        logic               cout;
        logic [P_RD_W-1:0]  rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch_taken;
        logic               ovf_exc;
    } ex_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_ex_payload_pack.sv
// Combinational derivation of the stage payload from raw ALU outputs and
// forwarded control fields.
module alu_ex_payload_pack
    import alu_ex_stage_pkg::*;
(
    input  logic [P_WIDTH-1:0] alu_result_i,
    input  logic               alu_zero_i,
    input  logic               alu_cout_i,
    input  logic               alu_ovf_i,
    input  logic [1:0]         alu_op_i,
    input  logic               ovf_trap_en_i,
    input  logic [P_RD_W-1:0]  rd_i,
    input  logic               reg_write_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               branch_i,
    output ex_payload_t        payload_o
);

    logic ovf_exc;
    logic is_add;

    assign is_add  = (alu_op_i == ALU_ADD);
    assign ovf_exc = alu_ovf_i & ovf_trap_en_i & is_add;

    always_comb begin
        payload_o              = '0;
        payload_o.result       = alu_result_i;
        payload_o.zero         = alu_zero_i;
        // Carry is only meaningful for arithmetic ops
        payload_o.cout         = alu_cout_i & is_add;
        payload_o.rd           = rd_i;
        payload_o.reg_write    = reg_write_i & ~ovf_exc;
        payload_o.mem_read     = mem_read_i;
        payload_o.mem_write    = mem_write_i & ~ovf_exc;
        payload_o.branch_taken = branch_i &
                                 ((alu_op_i == ALU_CMP) ? alu_result_i[0] : alu_zero_i);
        payload_o.ovf_exc      = ovf_exc;
    end

endmodule

// File: rtl/alu_ex_stage.sv
// EX/MEM pipeline stage: captures ALU payload behind a 2-entry skid buffer
// with a registered ready, and counts trapping overflows.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int WIDTH = P_WIDTH,
    parameter int RD_W  = P_RD_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_cout_i,
    input  logic             alu_ovf_i,
    input  logic [1:0]       alu_op_i,
    input  logic             ovf_trap_en_i,
    input  logic [RD_W-1:0]  rd_i,
    input  logic             reg_write_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             branch_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic [RD_W-1:0]  rd_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             branch_taken_o,
    output logic             ovf_exc_o,
    output logic [CNT_W-1:0] ovf_count_o
);

    ex_payload_t  pay_in;
    ex_payload_t  main_q, main_d;
    ex_payload_t  skid_q, skid_d;
    skid_state_t  state_q, state_d;
    logic         in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         accept;
    logic         consume;

    alu_ex_payload_pack u_pack (
        .alu_result_i  (alu_result_i),
        .alu_zero_i    (alu_zero_i),
        .alu_cout_i    (alu_cout_i),
        .alu_ovf_i     (alu_ovf_i),
        .alu_op_i      (alu_op_i),
        .ovf_trap_en_i (ovf_trap_en_i),
        .rd_i          (rd_i),
        .reg_write_i   (reg_write_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .branch_i      (branch_i),
        .payload_o     (pay_in)
    );

    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_q;
    assign consume     = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            if (accept && pay_in.ovf_exc && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
            case (state_q)
                ST_EMPTY: if (accept) begin
                    main_d  = pay_in;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        skid_d  = pay_in;
                        state_d = ST_TWO;
                    end else if (accept && consume) begin
                        main_d  = pay_in;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign result_o       = main_q.result;
    assign zero_o         = main_q.zero;
    assign cout_o         = main_q.cout;
    assign rd_o           = main_q.rd;
    assign reg_write_o    = main_q.reg_write;
    assign mem_read_o     = main_q.mem_read;
    assign mem_write_o    = main_q.mem_write;
    assign branch_taken_o = main_q.branch_taken;
    assign ovf_exc_o      = main_q.ovf_exc;
    assign ovf_count_o    = cnt_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: handshake, skid ordering, derived fields,
// flush, counter saturation and asynchronous reset.
module tb_alu_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i, alu_cout_i, alu_ovf_i;
    logic [1:0]  alu_op_i;
    logic        ovf_trap_en_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, mem_read_i, mem_write_i, branch_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o, cout_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_taken_o, ovf_exc_o;
    logic [15:0] ovf_count_o;

    int tests = 0;
    int errors = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk_i = ~clk_i;

    alu_ex_stage dut (
        .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .alu_cout_i(alu_cout_i), .alu_ovf_i(alu_ovf_i), .alu_op_i(alu_op_i),
        .ovf_trap_en_i(ovf_trap_en_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .branch_i(branch_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .branch_taken_o(branch_taken_o),
        .ovf_exc_o(ovf_exc_o), .ovf_count_o(ovf_count_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 0; in_valid_i = 0; alu_result_i = '0; alu_zero_i = 0;
        alu_cout_i = 0; alu_ovf_i = 0; alu_op_i = 2'd0; ovf_trap_en_i = 0;
        rd_i = '0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; branch_i = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] res, input logic [4:0] rd);
        idle_inputs();
        in_valid_i = 1; alu_op_i = op; alu_result_i = res; rd_i = rd;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready_i = 0;
        rst_n = 0;
        #12;
        tests++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'd0 || ovf_count_o !== 16'd0) begin
            $display("FAIL reset: valid=%b ready=%b result=%h cnt=%h, want 0 1 0 0",
                     out_valid_o, in_ready_o, result_o, ovf_count_o);
            errors++;
        end
        @(negedge clk_i);
        rst_n = 1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        out_ready_i = 1;
        send(2'd2, 32'h5, 5'd3);
        reg_write_i = 1;
        tick();
        tests++;
        if (out_valid_o !== 1 || result_o !== 32'h5 || rd_o !== 5'd3 || reg_write_o !== 1 || ovf_exc_o !== 0) begin
            $display("FAIL basic: valid=%b result=%h rd=%0d rw=%b exc=%b, want 1 5 3 1 0",
                     out_valid_o, result_o, rd_o, reg_write_o, ovf_exc_o);
            errors++;
        end
        idle_inputs();
        tick();
        tests++;
        if (out_valid_o !== 0) begin
            $display("FAIL basic_drain: valid=%b want 0", out_valid_o);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 0;
        send(2'd0, 32'hA, 5'd1);
        tick();
        send(2'd0, 32'hB, 5'd2);
        tests++;
        if (in_ready_o !== 1) begin
            $display("FAIL b2b_ready_one: ready=%b want 1", in_ready_o);
            errors++;
        end
        tick();
        send(2'd0, 32'hC, 5'd3);
        tests++;
        if (in_ready_o !== 0 || result_o !== 32'hA) begin
            $display("FAIL b2b_full: ready=%b result=%h, want 0 a", in_ready_o, result_o);
            errors++;
        end
        tick();
        tests++;
        if (in_ready_o !== 0 || out_valid_o !== 1 || result_o !== 32'hA || rd_o !== 5'd1) begin
            $display("FAIL b2b_stall: ready=%b valid=%b result=%h rd=%0d, want 0 1 a 1",
                     in_ready_o, out_valid_o, result_o, rd_o);
            errors++;
        end
        out_ready_i = 1;
        tick();
        tests++;
        if (out_valid_o !== 1 || result_o !== 32'hB || rd_o !== 5'd2) begin
            $display("FAIL b2b_second: valid=%b result=%h rd=%0d, want 1 b 2", out_valid_o, result_o, rd_o);
            errors++;
        end
        tick();
        idle_inputs();
        tests++;
        if (out_valid_o !== 1 || result_o !== 32'hC || rd_o !== 5'd3) begin
            $display("FAIL b2b_third: valid=%b result=%h rd=%0d, want 1 c 3", out_valid_o, result_o, rd_o);
            errors++;
        end
        tick();
        tests++;
        if (out_valid_o !== 0) begin
            $display("FAIL b2b_drain: valid=%b want 0", out_valid_o);
            errors++;
        end
    endtask

    task automatic test_overflow();
        out_ready_i = 1;
        send(2'd2, 32'h8000_0000, 5'd7);
        alu_ovf_i = 1; ovf_trap_en_i = 1; reg_write_i = 1; mem_write_i = 1; alu_cout_i = 1;
        tick();
        exp_cnt = exp_cnt + 1;
        tests++;
        if (ovf_exc_o !== 1 || reg_write_o !== 0 || mem_write_o !== 0 || ovf_count_o !== exp_cnt || cout_o !== 1) begin
            $display("FAIL ovf_trap: exc=%b rw=%b mw=%b cnt=%h cout=%b, want 1 0 0 %h 1",
                     ovf_exc_o, reg_write_o, mem_write_o, ovf_count_o, cout_o, exp_cnt);
            errors++;
        end
        send(2'd0, 32'h1, 5'd7);
        alu_ovf_i = 1; ovf_trap_en_i = 1; reg_write_i = 1; mem_write_i = 1; alu_cout_i = 1; mem_read_i = 1;
        tick();
        tests++;
        if (ovf_exc_o !== 0 || reg_write_o !== 1 || mem_write_o !== 1 || mem_read_o !== 1 ||
            ovf_count_o !== exp_cnt || cout_o !== 0) begin
            $display("FAIL ovf_non_add: exc=%b rw=%b mw=%b mr=%b cnt=%h cout=%b, want 0 1 1 1 %h 0",
                     ovf_exc_o, reg_write_o, mem_write_o, mem_read_o, ovf_count_o, cout_o, exp_cnt);
            errors++;
        end
        send(2'd2, 32'h1, 5'd7);
        alu_ovf_i = 1; ovf_trap_en_i = 0; reg_write_i = 1;
        tick();
        tests++;
        if (ovf_exc_o !== 0 || reg_write_o !== 1 || ovf_count_o !== exp_cnt) begin
            $display("FAIL ovf_untrapped: exc=%b rw=%b cnt=%h, want 0 1 %h",
                     ovf_exc_o, reg_write_o, ovf_count_o, exp_cnt);
            errors++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_branch();
        out_ready_i = 1;
        send(2'd3, 32'h1, 5'd0); branch_i = 1;
        tick();
        tests++;
        if (branch_taken_o !== 1) begin
            $display("FAIL br_cmp_taken: got %b want 1", branch_taken_o);
            errors++;
        end
        send(2'd2, 32'h0, 5'd0); branch_i = 1; alu_zero_i = 1;
        tick();
        tests++;
        if (branch_taken_o !== 1 || zero_o !== 1) begin
            $display("FAIL br_zero_taken: br=%b zero=%b want 1 1", branch_taken_o, zero_o);
            errors++;
        end
        send(2'd3, 32'h0, 5'd0); branch_i = 1; alu_zero_i = 1;
        tick();
        tests++;
        if (branch_taken_o !== 0) begin
            $display("FAIL br_cmp_not: got %b want 0", branch_taken_o);
            errors++;
        end
        send(2'd3, 32'h1, 5'd0); branch_i = 0;
        tick();
        tests++;
        if (branch_taken_o !== 0) begin
            $display("FAIL br_no_branch: got %b want 0", branch_taken_o);
            errors++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        out_ready_i = 0;
        send(2'd0, 32'h11, 5'd1);
        tick();
        send(2'd0, 32'h22, 5'd2);
        tick();
        send(2'd2, 32'hDD, 5'd9);
        alu_ovf_i = 1; ovf_trap_en_i = 1;
        flush_i = 1;
        tick();
        tests++;
        if (out_valid_o !== 0 || in_ready_o !== 1 || ovf_count_o !== exp_cnt) begin
            $display("FAIL flush: valid=%b ready=%b cnt=%h, want 0 1 %h",
                     out_valid_o, in_ready_o, ovf_count_o, exp_cnt);
            errors++;
        end
        idle_inputs();
        out_ready_i = 1;
        tick();
        tests++;
        if (out_valid_o !== 0) begin
            $display("FAIL flush_dropped: valid=%b result=%h, want valid 0", out_valid_o, result_o);
            errors++;
        end
        // A trapping overflow accepted in a flush cycle must not count
        send(2'd2, 32'h1, 5'd1);
        alu_ovf_i = 1; ovf_trap_en_i = 1; flush_i = 1;
        tick();
        idle_inputs();
        tests++;
        if (out_valid_o !== 0 || ovf_count_o !== exp_cnt) begin
            $display("FAIL flush_no_count: valid=%b cnt=%h, want 0 %h", out_valid_o, ovf_count_o, exp_cnt);
            errors++;
        end
    endtask

    task automatic test_saturation();
        int n;
        out_ready_i = 1;
        send(2'd2, 32'h0, 5'd4);
        alu_ovf_i = 1; ovf_trap_en_i = 1;
        n = 32'hFFFF - int'(exp_cnt);
        for (int i = 0; i < n; i++) tick();
        exp_cnt = 16'hFFFF;
        tests++;
        if (ovf_count_o !== exp_cnt) begin
            $display("FAIL sat_reach: cnt=%h want %h", ovf_count_o, exp_cnt);
            errors++;
        end
        tick();
        tests++;
        if (ovf_count_o !== 16'hFFFF || out_valid_o !== 1 || ovf_exc_o !== 1) begin
            $display("FAIL sat_hold: cnt=%h valid=%b exc=%b, want ffff 1 1", ovf_count_o, out_valid_o, ovf_exc_o);
            errors++;
        end
        out_ready_i = 0;
        send(2'd1, 32'hCAFE, 5'd5);
        tick();
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (out_valid_o !== 0 || in_ready_o !== 1 || result_o !== 0 || rd_o !== 0 ||
            ovf_exc_o !== 0 || ovf_count_o !== 0 || branch_taken_o !== 0) begin
            $display("FAIL async_reset: valid=%b ready=%b result=%h rd=%0d exc=%b cnt=%h br=%b, want 0 1 0 0 0 0 0",
                     out_valid_o, in_ready_o, result_o, rd_o, ovf_exc_o, ovf_count_o, branch_taken_o);
            errors++;
        end
        idle_inputs();
        @(negedge clk_i);
        rst_n = 1;
        tick();
        tests++;
        if (out_valid_o !== 0) begin
            $display("FAIL reset_no_partial: valid=%b want 0", out_valid_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_branch();
        test_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- EX/MEM pipeline stage placed directly downstream of the 32-bit ALU, which is built from the 1-bit ALU slices.
- Captures the ALU result and flags together with the forwarded control fields.
- Resolves branch-taken and overflow-trap conditions.
- Decouples ALU from memory stage with a valid/ready handshake and a 2-entry skid buffer, so backpressure never drops or reorders a result.

Parameters:
WIDTH, 32, datapath width of ALU result
RD_W, 5, destination register index width
CNT_W, 16, width of saturating overflow-event counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous pipeline flush (branch mispredict / exception)
in_valid_i  input  1  ALU-side transaction valid
in_ready_o  input->output  1  stage can accept a transaction this cycle
alu_result_i  input  WIDTH  ALU result word
alu_zero_i  input  1  ALU zero flag
alu_cout_i  input  1  ALU carry out (MSB slice)
alu_ovf_i  input  1  ALU overflow (MSB slice)
alu_op_i  input  2  ALU operation code (0 AND, 1 OR, 2 ADD/SUB, 3 compare)
ovf_trap_en_i  input  1  overflow trapping enabled for this instruction
rd_i  input  RD_W  destination register
reg_write_i, mem_read_i, mem_write_i, branch_i  input  1 each  control fields
out_valid_o  output  1  MEM-side transaction valid
out_ready_i  input  1  MEM stage accepts
result_o  output  WIDTH  registered result
zero_o, cout_o  output  1 each  registered flags
rd_o  output  RD_W  registered destination
reg_write_o, mem_read_o, mem_write_o  output  1 each  registered control (gated, see below)
branch_taken_o  output  1  branch resolved taken
ovf_exc_o  output  1  overflow exception for this transaction
ovf_count_o  output  CNT_W  saturating count of overflow exceptions

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid; out_valid_o=0; in_ready_o=1; all data/flag/control outputs=0; ovf_count_o=0.
- Transfer rules: input accepted when in_valid_i & in_ready_o; output consumed when out_valid_o & out_ready_i.
- Storage: main register drives outputs; skid register holds one overflow entry.
- States and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> TWO (new data into skid); consume without accept -> EMPTY; accept and consume -> ONE (new data into main).
  - TWO: consume -> ONE (skid moves to main); no accept possible.
- in_ready_o is registered, =1 exactly when the state is not TWO. It never depends combinationally on out_ready_i.
- Latency: accepted data appears at out_valid_o the next cycle.
- Ordering: strictly FIFO.
- Output stability: outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Derived fields, computed at capture:
  - ovf_exc = alu_ovf_i & ovf_trap_en_i & (alu_op_i==2).
  - reg_write stored = reg_write_i & ~ovf_exc.
  - mem_write stored = mem_write_i & ~ovf_exc.
  - branch_taken = branch_i & (alu_op_i==3 ? alu_result_i[0] : alu_zero_i).
  - cout is stored only for alu_op_i==2, otherwise 0.
- Flush:
  - Synchronous; highest priority.
  - Invalidates both entries; next cycle state EMPTY, out_valid_o=0, in_ready_o=1.
  - An input presented in the flush cycle is dropped. An output consumed in the flush cycle counts as delivered.
- Overflow counter:
  - Increments by 1 per accepted transaction with ovf_exc=1, unless flush_i is high that cycle.
  - Saturates at all-ones.
  - Not cleared by flush; cleared only by reset.
- Reset mid-transfer: all entries discarded immediately; no partial output.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_CMP=3.
  - A packed struct typedef for the stage payload (result, zero, cout, rd, reg_write, mem_read, mem_write, branch_taken, ovf_exc).
  - State encoding EMPTY/ONE/TWO.
- One natural sub-module: alu_ex_payload_pack, a combinational derivation of the payload struct from the raw inputs.
- Skid control and counter stay in the top.

Test Plan:
- Reset release, in_valid_i=1, alu_op=2, result=0x0000_0005, rd=3, reg_write=1, out_ready_i=1 -> next cycle out_valid_o=1, result_o=5, rd_o=3, reg_write_o=1, ovf_exc_o=0.
- Hold out_ready_i=0 and send three back-to-back inputs A, B, C:
  - A and B are accepted; in_ready_o=0 in the cycle after B is accepted; C stalls.
  - Then out_ready_i=1: outputs A, B, C appear in order with no gaps.
- alu_op=2, alu_ovf_i=1, ovf_trap_en_i=1, reg_write_i=1, mem_write_i=1 -> ovf_exc_o=1, reg_write_o=0, mem_write_o=0, ovf_count_o increments 0->1.
- Branch resolution:
  - alu_op=3, result=0x1, branch_i=1 -> branch_taken_o=1.
  - alu_op=2, zero=1, branch_i=1 -> branch_taken_o=1.
  - alu_op=3, result=0x0 -> branch_taken_o=0.
- State TWO with flush_i=1 and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed input never appears.
- Force ovf_count_o to 0xFFFF via 65535 trapping overflows, then one more -> ovf_count_o stays 0xFFFF. Assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
